// File: rtl/sr_cmd_pkg.sv
// Shared types for the SR command conditioner: FSM states and the
// command selected when a pulse is launched.
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } sr_state_t;

  typedef enum logic {
    CMD_SET   = 1'b0,
    CMD_RESET = 1'b1
  } sr_cmd_t;

endpackage

// File: rtl/sr_debounce.sv
// One button channel: two-flop synchroniser, stability counter and
// rising-edge detector on the debounced level.
module sr_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          flip;

  // rise is combinational so pending can be set on the edge deb goes high
  assign flip = (s2 != deb) && (cnt == CNT_LAST);
  assign rise = flip && s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      deb <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 != deb) begin
        if (flip) begin
          deb <= s2;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sr_cmd_conditioner.sv
// Turns two raw buttons into clean, mutually exclusive set/reset pulses
// for the SR flip-flop, with one pending slot per channel and arbitration.
module sr_cmd_conditioner
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 1,
  parameter int GAP_CYCLES      = 2,
  parameter int RESET_PRIORITY  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic set_req,
  input  logic reset_req,
  output logic sr_set,
  output logic sr_reset,
  output logic conflict,
  output logic busy
);

  localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  sr_state_t     state;
  sr_state_t     state_n;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_n;
  sr_cmd_t       sel;
  logic          set_nxt;
  logic          reset_nxt;
  logic          conflict_nxt;
  logic          clr_set;
  logic          clr_reset;
  logic          pending_set;
  logic          pending_reset;
  logic          rise_set;
  logic          rise_reset;
  logic          set_deb_unused;
  logic          reset_deb_unused;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_set (
    .clk   (clk),
    .reset (reset),
    .raw   (set_req),
    .deb   (set_deb_unused),
    .rise  (rise_set)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_reset (
    .clk   (clk),
    .reset (reset),
    .raw   (reset_req),
    .deb   (reset_deb_unused),
    .rise  (rise_reset)
  );

  always_comb begin
    state_n      = state;
    tcnt_n       = tcnt;
    set_nxt      = sr_set;
    reset_nxt    = sr_reset;
    conflict_nxt = 1'b0;
    clr_set      = 1'b0;
    clr_reset    = 1'b0;
    sel          = CMD_SET;
    case (state)
      IDLE: begin
        set_nxt   = 1'b0;
        reset_nxt = 1'b0;
        if (pending_set || pending_reset) begin
          if (pending_set && pending_reset) begin
            sel          = (RESET_PRIORITY != 0) ? CMD_RESET : CMD_SET;
            conflict_nxt = 1'b1;
            clr_set      = 1'b1;
            clr_reset    = 1'b1;
          end else if (pending_reset) begin
            sel       = CMD_RESET;
            clr_reset = 1'b1;
          end else begin
            sel     = CMD_SET;
            clr_set = 1'b1;
          end
          set_nxt   = (sel == CMD_SET);
          reset_nxt = (sel == CMD_RESET);
          state_n   = PULSE;
          tcnt_n    = '0;
        end
      end
      PULSE: begin
        if (tcnt == PULSE_LAST) begin
          set_nxt   = 1'b0;
          reset_nxt = 1'b0;
          tcnt_n    = '0;
          state_n   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      GAP: begin
        set_nxt   = 1'b0;
        reset_nxt = 1'b0;
        if (tcnt == GAP_LAST) begin
          tcnt_n  = '0;
          state_n = IDLE;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      default: begin
        set_nxt   = 1'b0;
        reset_nxt = 1'b0;
        tcnt_n    = '0;
        state_n   = IDLE;
      end
    endcase
  end

  // A rise landing on the same edge as its clear is kept: set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      tcnt          <= '0;
      sr_set        <= 1'b0;
      sr_reset      <= 1'b0;
      conflict      <= 1'b0;
      busy          <= 1'b0;
      pending_set   <= 1'b0;
      pending_reset <= 1'b0;
    end else begin
      state         <= state_n;
      tcnt          <= tcnt_n;
      sr_set        <= set_nxt;
      sr_reset      <= reset_nxt;
      conflict      <= conflict_nxt;
      busy          <= (state_n != IDLE);
      pending_set   <= (pending_set & ~clr_set) | rise_set;
      pending_reset <= (pending_reset & ~clr_reset) | rise_reset;
    end
  end

endmodule
